ram_access_arbiter: RTL and testbench

//  Sequences every access to the 512x32 RAM and shares it between two requesters:

---
 rtl/ram_access_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Two-port (fetch / load-store) sequencer for a level-sensitive 512x32 RAM.
// Round-robin arbitration, registered strobes/address/data, one-cycle acks.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               sel_d_q, sel_d_d;
    logic               last_d_q, last_d_d;
    logic               grant_d;
    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [DATA_W-1:0]  i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               ram_read_q, ram_read_d;
    logic               ram_write_q, ram_write_d;
    logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
    logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic               busy_q, busy_d;

    // D wins only when alone or when I had the previous grant.
    assign grant_d = d_req && (!i_req || !last_d_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        sel_d_d       = sel_d_q;
        last_d_d      = last_d_q;
        i_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        ram_read_d    = ram_read_q;
        ram_write_d   = ram_write_q;
        ram_address_d = ram_address_q;
        ram_wdata_d   = ram_wdata_q;
        busy_d        = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    sel_d_d       = grant_d;
                    last_d_d      = grant_d;
                    we_d          = grant_d && d_we;
                    ram_address_d = grant_d ? d_addr : i_addr;
                    if (grant_d && d_we) begin
                        ram_wdata_d = d_wdata;
                    end
                    ram_read_d    = !(grant_d && d_we);
                    ram_write_d   = grant_d && d_we;
                    cnt_d         = CNT_W'(WAIT_CYC - 1);
                    busy_d        = 1'b1;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (sel_d_q) begin
                            d_rdata_d = ram_rdata;
                        end else begin
                            i_rdata_d = ram_rdata;
                        end
                    end
                    ram_read_d  = 1'b0;
                    ram_write_d = 1'b0;
                    d_ack_d     = sel_d_q;
                    i_ack_d     = !sel_d_q;
                    state_d     = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ram_read_d  = 1'b0;
                ram_write_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            sel_d_q       <= 1'b0;
            last_d_q      <= 1'b1;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_address_q <= '0;
            ram_wdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            sel_d_q       <= sel_d_d;
            last_d_q      <= last_d_d;
            i_ack_q       <= i_ack_d;
            d_ack_q       <= d_ack_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            ram_address_q <= ram_address_d;
            ram_wdata_q   <= ram_wdata_d;
            busy_q        <= busy_d;
        end
    end

    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign ram_address = ram_address_q;
    assign ram_wdata   = ram_wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: one instance with WAIT_CYC=1, one with WAIT_CYC=3,
// each attached to a simple level-sensitive RAM model.
module tb_ram_access_arbiter;

    logic        clock;
    logic        clear;

    logic        i_req, d_req, d_we;
    logic [8:0]  i_addr, d_addr;
    logic [31:0] d_wdata;
    logic        i_ack, d_ack, ram_read, ram_write, busy;
    logic [31:0] i_rdata, d_rdata, ram_wdata, ram_rdata;
    logic [8:0]  ram_address;

    logic        i_req3, d_req3, d_we3;
    logic [8:0]  i_addr3, d_addr3;
    logic [31:0] d_wdata3;
    logic        i_ack3, d_ack3, ram_read3, ram_write3, busy3;
    logic [31:0] i_rdata3, d_rdata3, ram_wdata3, ram_rdata3;
    logic [8:0]  ram_address3;

    logic [31:0] mem1 [512];
    logic [31:0] mem3 [512];
    logic        pre_en1, pre_en3;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;
    int          wr_count1;

    int errors;
    int checks;

    ram_access_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYC(1)) dut (
        .clock(clock), .clear(clear),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    ram_access_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYC(3)) dut3 (
        .clock(clock), .clear(clear),
        .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .ram_read(ram_read3), .ram_write(ram_write3), .ram_address(ram_address3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
    );

    // Level-sensitive RAM models: read is combinational, a held write strobe writes each edge.
    assign ram_rdata  = mem1[ram_address];
    assign ram_rdata3 = mem3[ram_address3];

    always @(posedge clock) begin
        if (pre_en1) begin
            mem1[pre_addr] <= pre_data;
        end else if (ram_write) begin
            mem1[ram_address] <= ram_wdata;
            wr_count1 <= wr_count1 + 1;
        end
    end

    always @(posedge clock) begin
        if (pre_en3) begin
            mem3[pre_addr] <= pre_data;
        end else if (ram_write3) begin
            mem3[ram_address3] <= ram_wdata3;
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input bit which3, input logic [8:0] a, input logic [31:0] v);
        pre_addr = a;
        pre_data = v;
        pre_en1  = !which3;
        pre_en3  = which3;
        tick();
        pre_en1  = 1'b0;
        pre_en3  = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        i_req3 = 0; d_req3 = 0; d_we3 = 0; i_addr3 = '0; d_addr3 = '0; d_wdata3 = '0;
        pre_en1 = 0; pre_en3 = 0; pre_addr = '0; pre_data = '0;
        wr_count1 = 0;
        tick();
        preload(1'b0, 9'h010, 32'hDEADBEEF);
        preload(1'b0, 9'h1FF, 32'h00000000);
        preload(1'b0, 9'h020, 32'h00000000);
        preload(1'b0, 9'h030, 32'h0BADBAD0);
        preload(1'b0, 9'h040, 32'h11111111);
        preload(1'b0, 9'h041, 32'h22222222);
        preload(1'b0, 9'h050, 32'h77777777);
        preload(1'b1, 9'h0AB, 32'hCAFEF00D);
        tick();
        checks++;
        if ({ram_read, ram_write, i_ack, d_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {ram_read, ram_write, i_ack, d_ack, busy});
        end
        checks++;
        if ({ram_address, ram_wdata, i_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h i_rdata=%h d_rdata=%h required all 0",
                     ram_address, ram_wdata, i_rdata, d_rdata);
        end
        clear = 1'b1;
        tick();
    endtask

    task automatic test_fetch_read();
        i_req = 1'b1; i_addr = 9'h010;
        tick();
        checks++;
        if ({ram_read, ram_write, busy, i_ack} !== 4'b1010 || ram_address !== 9'h010) begin
            errors++;
            $display("FAIL fetch_access: rd/wr/busy/ack=%b addr=%h required 1010 addr=010",
                     {ram_read, ram_write, busy, i_ack}, ram_address);
        end
        tick();
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || ram_read !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_ack: i_ack=%b d_ack=%b rd=%b i_rdata=%h required 1 0 0 deadbeef",
                     i_ack, d_ack, ram_read, i_rdata);
        end
        i_req = 1'b0;
        tick();
        checks++;
        if (i_ack !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_idle: i_ack=%b busy=%b i_rdata=%h required 0 0 deadbeef",
                     i_ack, busy, i_rdata);
        end
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h1FF; d_wdata = 32'h12345678;
        tick();
        checks++;
        if ({ram_read, ram_write} !== 2'b01 || ram_address !== 9'h1FF || ram_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL store_access: rd/wr=%b addr=%h wdata=%h required 01 1ff 12345678",
                     {ram_read, ram_write}, ram_address, ram_wdata);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || ram_write !== 1'b0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL store_ack: d_ack=%b wr=%b d_rdata=%h required 1 0 00000000",
                     d_ack, ram_write, d_rdata);
        end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
        tick();
        checks++;
        if ({ram_read, ram_write} !== 2'b10 || ram_address !== 9'h1FF) begin
            errors++;
            $display("FAIL load_access: rd/wr=%b addr=%h required 10 1ff", {ram_read, ram_write}, ram_address);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL load_ack: d_ack=%b d_rdata=%h required 1 12345678", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_i, exp_d;
        clear = 1'b0;
        i_req = 1'b1; i_addr = 9'h040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h041;
        tick();
        clear = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_i = (k == 2) || (k == 8);
            exp_d = (k == 5) || (k == 11);
            checks++;
            if (i_ack !== exp_i || d_ack !== exp_d) begin
                errors++;
                $display("FAIL rr_ack_cycle%0d: i_ack=%b d_ack=%b required %b %b", k, i_ack, d_ack, exp_i, exp_d);
            end
            if (k == 2) begin
                checks++;
                if (i_rdata !== 32'h11111111) begin
                    errors++;
                    $display("FAIL rr_i_rdata: got %h required 11111111", i_rdata);
                end
            end
            if (k == 5) begin
                checks++;
                if (d_rdata !== 32'h22222222) begin
                    errors++;
                    $display("FAIL rr_d_rdata: got %h required 22222222", d_rdata);
                end
            end
            if (k == 11) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
    endtask

    task automatic test_wait3();
        logic exp_rd, exp_ack;
        d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 9'h0AB;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_rd  = (k >= 1) && (k <= 3);
            exp_ack = (k == 4);
            checks++;
            if (ram_read3 !== exp_rd || ram_write3 !== 1'b0 || d_ack3 !== exp_ack) begin
                errors++;
                $display("FAIL w3_cycle%0d: rd=%b wr=%b d_ack=%b required %b 0 %b",
                         k, ram_read3, ram_write3, d_ack3, exp_rd, exp_ack);
            end
            if (k <= 4) begin
                checks++;
                if (ram_address3 !== 9'h0AB) begin
                    errors++;
                    $display("FAIL w3_addr_cycle%0d: got %h required 0ab", k, ram_address3);
                end
            end
            if (k == 4) begin
                checks++;
                if (d_rdata3 !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL w3_rdata: got %h required cafef00d", d_rdata3);
                end
                d_req3 = 1'b0;
            end
        end
    endtask

    task automatic test_midaccess_change();
        int wr_before;
        wr_before = wr_count1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h020; d_wdata = 32'h55AA55AA;
        tick();
        d_addr = 9'h030; d_wdata = 32'hFFFFFFFF;
        checks++;
        if (ram_write !== 1'b1 || ram_address !== 9'h020 || ram_wdata !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL mid_access: wr=%b addr=%h wdata=%h required 1 020 55aa55aa",
                     ram_write, ram_address, ram_wdata);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || ram_address !== 9'h020 || ram_wdata !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL mid_ack: d_ack=%b addr=%h wdata=%h required 1 020 55aa55aa",
                     d_ack, ram_address, ram_wdata);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if (mem1[9'h020] !== 32'h55AA55AA || mem1[9'h030] !== 32'h0BADBAD0 || (wr_count1 - wr_before) !== 1) begin
            errors++;
            $display("FAIL mid_ram: m020=%h m030=%h writes=%0d required 55aa55aa 0badbad0 1",
                     mem1[9'h020], mem1[9'h030], wr_count1 - wr_before);
        end
    endtask

    task automatic test_reset_midaccess();
        i_req = 1'b1; i_addr = 9'h010;
        tick();
        tick();
        i_req = 1'b0;
        tick();
        checks++;
        if (i_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL abort_pre: i_rdata=%h required deadbeef", i_rdata);
        end
        i_req = 1'b1; i_addr = 9'h050;
        tick();
        checks++;
        if (ram_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_access: rd=%b busy=%b required 1 1", ram_read, busy);
        end
        clear = 1'b0;
        i_req = 1'b0;
        tick();
        checks++;
        if ({ram_read, ram_write, busy, i_ack, d_ack} !== 5'b0 || i_rdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset: rd/wr/busy/i_ack/d_ack=%b i_rdata=%h required 00000 00000000",
                     {ram_read, ram_write, busy, i_ack, d_ack}, i_rdata);
        end
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (i_ack !== 1'b0 || ram_read !== 1'b0) begin
                errors++;
                $display("FAIL abort_after%0d: i_ack=%b rd=%b required 0 0", k, i_ack, ram_read);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fetch_read();
        test_store_load();
        test_round_robin();
        test_wait3();
        test_midaccess_change();
        test_reset_midaccess();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
